// File: rtl/vga_disp_ctrl.sv
// VGA timing generator with a framebuffer read port, a pixel-replicated image window
// and a frame-synchronous crosshair cursor drawn by inverting the underlying pixels.
module vga_disp_ctrl #(
    parameter int H_SYNC   = 120,
    parameter int H_BP     = 64,
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 56,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 23,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 37,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int IMG_W    = 256,
    parameter int IMG_H    = 256,
    parameter int X_OFF    = 272,
    parameter int Y_OFF    = 172,
    parameter int SCALE    = 1,
    parameter int RD_LAT   = 1,
    parameter int CUR_HALF = 5,
    localparam int AW      = $clog2(IMG_W * IMG_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    cur_x,
    input  logic [7:0]    cur_y,
    input  logic          cur_en,
    output logic [AW-1:0] rd_addr,
    input  logic [11:0]   rd_data,
    output logic [3:0]    vga_r,
    output logic [3:0]    vga_g,
    output logic [3:0]    vga_b,
    output logic          vga_hs,
    output logic          vga_vs,
    output logic          de,
    output logic          frame_start
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int H_ACT0  = H_SYNC + H_BP;
    localparam int V_ACT0  = V_SYNC + V_BP;
    localparam int SHIFT   = $clog2(SCALE);

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic win;
        logic cur;
    } flags_t;

    logic          run;
    logic [HW-1:0] hcount, h_next;
    logic [VW-1:0] vcount, v_next;
    int            ax, ay, ix_n, iy_n;
    logic          win_n, win_q;
    logic [11:0]   ix_q, iy_q;
    logic [7:0]    cur_x_l, cur_y_l;
    logic          cur_en_l;
    int            dx, dy;
    flags_t        raw;
    flags_t        pipe [RD_LAT];
    flags_t        dly;
    logic [11:0]   colour;

    // run is low for one clock after reset so the first edge presents (0,0) with frame_start.
    // NOTE: combinational blocks assign every output a default first, so no path can infer a latch.
    always_comb begin
        h_next = hcount;
        v_next = vcount;
        if (run) begin
            if (hcount == HW'(H_TOTAL - 1)) begin
                h_next = '0;
                v_next = (vcount == VW'(V_TOTAL - 1)) ? '0 : vcount + 1'b1;
            end else begin
                h_next = hcount + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run         <= 1'b0;
            hcount      <= '0;
            vcount      <= '0;
            frame_start <= 1'b0;
        end else begin
            run         <= 1'b1;
            hcount      <= h_next;
            vcount      <= v_next;
            frame_start <= (h_next == '0) && (v_next == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_x_l  <= '0;
            cur_y_l  <= '0;
            cur_en_l <= 1'b0;
        end else if (frame_start) begin
            cur_x_l  <= cur_x;
            cur_y_l  <= cur_y;
            cur_en_l <= cur_en;
        end
    end

    // Window decode runs on the next counter values so rd_addr lines up with the counters.
    always_comb begin
        ax    = int'(h_next) - H_ACT0;
        ay    = int'(v_next) - V_ACT0;
        win_n = (ax >= X_OFF) && (ax < X_OFF + IMG_W * SCALE) && (ax < H_ACTIVE) &&
                (ay >= Y_OFF) && (ay < Y_OFF + IMG_H * SCALE) && (ay < V_ACTIVE);
        ix_n  = (ax - X_OFF) >>> SHIFT;
        iy_n  = (ay - Y_OFF) >>> SHIFT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr <= '0;
            win_q   <= 1'b0;
            ix_q    <= '0;
            iy_q    <= '0;
        end else begin
            win_q <= win_n;
            ix_q  <= 12'(ix_n);
            iy_q  <= 12'(iy_n);
            if (win_n) begin
                rd_addr <= AW'(iy_n * IMG_W + ix_n);
            end
        end
    end

    // Signed distances keep arms from wrapping across the image edge.
    always_comb begin
        dx      = int'(ix_q) - int'(cur_x_l);
        dy      = int'(iy_q) - int'(cur_y_l);
        raw     = '0;
        raw.hs  = run && (int'(hcount) < H_SYNC);
        raw.vs  = run && (int'(vcount) < V_SYNC);
        raw.de  = run && (int'(hcount) >= H_ACT0) && (int'(hcount) < H_ACT0 + H_ACTIVE) &&
                  (int'(vcount) >= V_ACT0) && (int'(vcount) < V_ACT0 + V_ACTIVE);
        raw.win = win_q;
        raw.cur = cur_en_l && win_q &&
                  (((dx == 0) && ((dy < 0 ? -dy : dy) <= CUR_HALF)) ||
                   ((dy == 0) && ((dx < 0 ? -dx : dx) <= CUR_HALF)));
    end

    // NOTE: this delay line is a handful of flops, so it is reset with the rest of the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= raw;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign dly = pipe[RD_LAT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            colour <= '0;
            de     <= 1'b0;
            vga_hs <= ~HS_POL;
            vga_vs <= ~VS_POL;
        end else begin
            de     <= dly.de;
            vga_hs <= dly.hs ? HS_POL : ~HS_POL;
            vga_vs <= dly.vs ? VS_POL : ~VS_POL;
            if (dly.de && dly.win) begin
                colour <= dly.cur ? ~rd_data : rd_data;
            end else begin
                colour <= '0;
            end
        end
    end

    assign {vga_b, vga_g, vga_r} = colour;

endmodule

// File: tb/tb_vga_disp_ctrl.sv
// Scoreboard bench for vga_disp_ctrl: three small-timing instances (scale 1/2/4, read
// latency 1/2/3, both sync polarities) checked every clock against an independent model.
module tb_vga_disp_ctrl;

    typedef struct packed {
        int hs; int hb; int ha; int hf;
        int vs; int vb; int va; int vf;
        bit hpol; bit vpol;
        int iw; int ih; int xo; int yo; int sc; int lat; int ch;
    } cfg_t;

    localparam cfg_t CFG_A = '{hs:4, hb:3, ha:40, hf:3, vs:2, vb:2, va:36, vf:2, hpol:1'b0, vpol:1'b0,
                               iw:32, ih:32, xo:5, yo:3, sc:1, lat:1, ch:5};
    localparam cfg_t CFG_B = '{hs:4, hb:3, ha:40, hf:3, vs:2, vb:2, va:36, vf:2, hpol:1'b0, vpol:1'b0,
                               iw:16, ih:16, xo:6, yo:2, sc:2, lat:2, ch:3};
    localparam cfg_t CFG_C = '{hs:4, hb:3, ha:40, hf:3, vs:2, vb:2, va:36, vf:2, hpol:1'b1, vpol:1'b1,
                               iw:8, ih:8, xo:4, yo:4, sc:4, lat:3, ch:2};
    localparam int AW_A = $clog2(CFG_A.iw * CFG_A.ih);
    localparam int AW_B = $clog2(CFG_B.iw * CFG_B.ih);
    localparam int AW_C = $clog2(CFG_C.iw * CFG_C.ih);

    logic             clk = 1'b0;
    logic [2:0]       rst_v;
    logic [7:0]       cur_x, cur_y;
    logic             cur_en;
    logic [AW_A-1:0]  addr_a;
    logic [AW_B-1:0]  addr_b;
    logic [AW_C-1:0]  addr_c;
    logic [11:0]      data_a, data_b, data_c;
    logic [3:0]       r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;
    logic             hs_a, vs_a, de_a, fs_a, hs_b, vs_b, de_b, fs_b, hs_c, vs_c, de_c, fs_c;
    logic [31:0]      obs [3];
    logic [11:0]      dl [3][3];
    int               n_vec, n_err;

    always #5 clk = ~clk;

    vga_disp_ctrl #(.H_SYNC(CFG_A.hs), .H_BP(CFG_A.hb), .H_ACTIVE(CFG_A.ha), .H_FP(CFG_A.hf),
                    .V_SYNC(CFG_A.vs), .V_BP(CFG_A.vb), .V_ACTIVE(CFG_A.va), .V_FP(CFG_A.vf),
                    .HS_POL(CFG_A.hpol), .VS_POL(CFG_A.vpol), .IMG_W(CFG_A.iw), .IMG_H(CFG_A.ih),
                    .X_OFF(CFG_A.xo), .Y_OFF(CFG_A.yo), .SCALE(CFG_A.sc), .RD_LAT(CFG_A.lat),
                    .CUR_HALF(CFG_A.ch))
    u_a (.clk(clk), .rst(rst_v[0]), .cur_x(cur_x), .cur_y(cur_y), .cur_en(cur_en),
         .rd_addr(addr_a), .rd_data(data_a), .vga_r(r_a), .vga_g(g_a), .vga_b(b_a),
         .vga_hs(hs_a), .vga_vs(vs_a), .de(de_a), .frame_start(fs_a));

    vga_disp_ctrl #(.H_SYNC(CFG_B.hs), .H_BP(CFG_B.hb), .H_ACTIVE(CFG_B.ha), .H_FP(CFG_B.hf),
                    .V_SYNC(CFG_B.vs), .V_BP(CFG_B.vb), .V_ACTIVE(CFG_B.va), .V_FP(CFG_B.vf),
                    .HS_POL(CFG_B.hpol), .VS_POL(CFG_B.vpol), .IMG_W(CFG_B.iw), .IMG_H(CFG_B.ih),
                    .X_OFF(CFG_B.xo), .Y_OFF(CFG_B.yo), .SCALE(CFG_B.sc), .RD_LAT(CFG_B.lat),
                    .CUR_HALF(CFG_B.ch))
    u_b (.clk(clk), .rst(rst_v[1]), .cur_x(cur_x), .cur_y(cur_y), .cur_en(cur_en),
         .rd_addr(addr_b), .rd_data(data_b), .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
         .vga_hs(hs_b), .vga_vs(vs_b), .de(de_b), .frame_start(fs_b));

    vga_disp_ctrl #(.H_SYNC(CFG_C.hs), .H_BP(CFG_C.hb), .H_ACTIVE(CFG_C.ha), .H_FP(CFG_C.hf),
                    .V_SYNC(CFG_C.vs), .V_BP(CFG_C.vb), .V_ACTIVE(CFG_C.va), .V_FP(CFG_C.vf),
                    .HS_POL(CFG_C.hpol), .VS_POL(CFG_C.vpol), .IMG_W(CFG_C.iw), .IMG_H(CFG_C.ih),
                    .X_OFF(CFG_C.xo), .Y_OFF(CFG_C.yo), .SCALE(CFG_C.sc), .RD_LAT(CFG_C.lat),
                    .CUR_HALF(CFG_C.ch))
    u_c (.clk(clk), .rst(rst_v[2]), .cur_x(cur_x), .cur_y(cur_y), .cur_en(cur_en),
         .rd_addr(addr_c), .rd_data(data_c), .vga_r(r_c), .vga_g(g_c), .vga_b(b_c),
         .vga_hs(hs_c), .vga_vs(vs_c), .de(de_c), .frame_start(fs_c));

    // Framebuffer model: each word holds its own address, returned after the read latency.
    always @(posedge clk) begin
        dl[0][0] <= 12'(addr_a);
        dl[1][0] <= 12'(addr_b);
        dl[2][0] <= 12'(addr_c);
        for (int i = 0; i < 3; i++) begin
            dl[i][1] <= dl[i][0];
            dl[i][2] <= dl[i][1];
        end
    end
    assign data_a = dl[0][CFG_A.lat-1];
    assign data_b = dl[1][CFG_B.lat-1];
    assign data_c = dl[2][CFG_C.lat-1];

    // Observation word: {frame_start, rd_addr, colour, hs, vs, de}.
    assign obs[0] = {fs_a, 16'(addr_a), b_a, g_a, r_a, hs_a, vs_a, de_a};
    assign obs[1] = {fs_b, 16'(addr_b), b_b, g_b, r_b, hs_b, vs_b, de_b};
    assign obs[2] = {fs_c, 16'(addr_c), b_c, g_c, r_c, hs_c, vs_c, de_c};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic cfg_t get_cfg(input int idx);
        case (idx)
            0:       return CFG_A;
            1:       return CFG_B;
            default: return CFG_C;
        endcase
    endfunction

    // Expected delayed outputs {colour, hs, vs, de} for the pixel at position q after restart.
    task automatic model(input cfg_t c, input int q, input int cx, input int cy, input bit cen,
                         inout int last, output logic [14:0] d);
        int ht, vt, p, h, v, ax, ay, ix, iy;
        bit de_e, win, hit;
        logic [11:0] data, col;
        ht   = c.hs + c.hb + c.ha + c.hf;
        vt   = c.vs + c.vb + c.va + c.vf;
        p    = q % (ht * vt);
        h    = p % ht;
        v    = p / ht;
        ax   = h - c.hs - c.hb;
        ay   = v - c.vs - c.vb;
        de_e = (ax >= 0) && (ax < c.ha) && (ay >= 0) && (ay < c.va);
        win  = de_e && (ax >= c.xo) && (ax < c.xo + c.iw * c.sc) &&
               (ay >= c.yo) && (ay < c.yo + c.ih * c.sc);
        col  = 12'h000;
        if (win) begin
            ix   = (ax - c.xo) / c.sc;
            iy   = (ay - c.yo) / c.sc;
            last = iy * c.iw + ix;
            data = 12'(last);
            hit  = cen && (((ix == cx) && ((iy > cy ? iy - cy : cy - iy) <= c.ch)) ||
                           ((iy == cy) && ((ix > cx ? ix - cx : cx - ix) <= c.ch)));
            col  = hit ? ~data : data;
        end
        d = {col, (h < c.hs) ? c.hpol : ~c.hpol, (v < c.vs) ? c.vpol : ~c.vpol, de_e};
    endtask

    // Reset one instance (possibly mid-frame), then score it for the given number of clocks.
    task automatic run_cfg(input int idx, input int frames, input int extra);
        cfg_t        c;
        int          fr, last, lx, ly, qpos;
        bit          len;
        logic [14:0] d, idle, e;
        logic [14:0] sb [$];
        string       nm;
        c    = get_cfg(idx);
        fr   = (c.hs + c.hb + c.ha + c.hf) * (c.vs + c.vb + c.va + c.vf);
        idle = {12'h000, ~c.hpol, ~c.vpol, 1'b0};
        nm   = (idx == 0) ? "a" : (idx == 1) ? "b" : "c";
        last = 0; lx = 0; ly = 0; len = 1'b0;
        @(negedge clk);
        rst_v[idx] = 1'b1;
        #1;
        check({"rst_", nm}, obs[idx], {1'b0, 16'h0, idle});
        @(negedge clk);
        rst_v[idx] = 1'b0;
        check({"idle_", nm}, obs[idx], {1'b0, 16'h0, idle});
        for (int i = 0; i <= c.lat; i++) sb.push_back(idle);
        for (int k = 1; k <= frames * fr + extra; k++) begin
            @(negedge clk);
            qpos = k - 1;
            case (idx)
                0: if (qpos == fr / 2) begin cur_x = 8'd10; cur_y = 8'd10; end
                   else if (qpos == fr + fr / 2) cur_x = 8'd20;
                   else if (qpos == 2 * fr + fr / 2) begin cur_x = 8'd34; cur_y = 8'd3; end
                1: if (qpos == fr / 2) begin cur_x = 8'd5; cur_y = 8'd7; end
                2: if (qpos == fr / 2) begin cur_x = 8'd9; cur_y = 8'd2; end
                   else if (qpos == fr + fr / 2) cur_en = 1'b0;
                default: ;
            endcase
            model(c, qpos, lx, ly, len, last, d);
            sb.push_back(d);
            if (qpos % fr == 0) begin
                lx = int'(cur_x); ly = int'(cur_y); len = cur_en;
            end
            e = sb.pop_front();
            check($sformatf("pix_%s@%0d", nm, qpos), obs[idx], {qpos % fr == 0, 16'(last), e});
        end
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        rst_v  = 3'b111;
        cur_x  = 8'd0;
        cur_y  = 8'd0;
        cur_en = 1'b1;
        repeat (3) @(negedge clk);
        run_cfg(0, 4, 20);
        run_cfg(1, 2, 10);
        cur_x = 8'd1;
        cur_y = 8'd6;
        run_cfg(2, 1, 517);
        run_cfg(2, 2, 10);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
